// File: rtl/half_adder_pkg.sv
// Shared constants and result type for the registered half adder.
// The carry statistics counter is built only when HALF_ADDER_STATS_EN is defined.
package half_adder_pkg;

    localparam int WIDTH_DEF = 1;
    localparam int CNT_W     = 16;
    localparam int MAX_W     = 64;

    // Sized for the widest legal operand; narrower instances use the low bits of sum.
    typedef struct packed {
        logic             c_out;
        logic [MAX_W-1:0] sum;
    } result_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/half_adder_core.sv
// Purely combinational WIDTH-bit adder with no carry-in; c_out is bit WIDTH of a+b.
module half_adder_core
    import half_adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    logic [WIDTH:0] w_full;

    assign w_full = {1'b0, a} + {1'b0, b};
    assign sum    = w_full[WIDTH-1:0];
    assign c_out  = w_full[WIDTH];

endmodule

// File: rtl/half_adder.sv
// Registered half adder with a valid/ready stage on each side, one result per cycle.
// Define HALF_ADDER_STATS_EN to add the saturating carry_cnt output.
module half_adder
    import half_adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             out_valid,
    input  logic             out_ready
`ifdef HALF_ADDER_STATS_EN
    ,
    output logic [CNT_W-1:0] carry_cnt
`endif
);

    // Handshake: a side transfers on a rising edge where its valid and ready are both 1.
    // The stage can take a new pair whenever it is empty or its result leaves this edge.
    logic [WIDTH-1:0] w_sum;
    logic             w_c_out;
    logic             w_in_xfer;
    logic             w_out_xfer;
    result_t          w_res;
    result_t          r_res;
    logic             r_valid;

    half_adder_core #(.WIDTH(WIDTH)) u_core (
        .a     (a),
        .b     (b),
        .sum   (w_sum),
        .c_out (w_c_out)
    );

    always_comb begin
        w_res                = '0;
        w_res.sum[WIDTH-1:0] = w_sum;
        w_res.c_out          = w_c_out;
    end

    assign in_ready   = !r_valid || out_ready;
    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = r_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_res   <= '0;
        end else if (w_in_xfer) begin
            r_valid <= 1'b1;
            r_res   <= w_res;
        end else if (w_out_xfer) begin
            r_valid <= 1'b0;
        end
    end

    assign sum       = r_res.sum[WIDTH-1:0];
    assign c_out     = r_res.c_out;
    assign out_valid = r_valid;

    // Upper struct bits stay zero for narrow instances and are never read.
    generate
        if (WIDTH < MAX_W) begin : g_pad
            logic w_unused_pad;
            assign w_unused_pad = |r_res.sum[MAX_W-1:WIDTH];
        end
    endgenerate

`ifdef HALF_ADDER_STATS_EN
    logic [CNT_W-1:0] r_carry_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_carry_cnt <= '0;
        end else if (w_in_xfer && w_c_out) begin
            r_carry_cnt <= sat_inc(r_carry_cnt);
        end
    end

    assign carry_cnt = r_carry_cnt;
`endif

endmodule

// File: tb/tb_half_adder.sv
// Bench for half_adder: an 8-bit instance under scoreboard checking and a 1-bit instance
// for the truth-table sequence. Define HALF_ADDER_STATS_EN to also exercise carry_cnt.
module tb_half_adder;

  logic       clk;
  logic       rst_n;
  logic [7:0] a, b, sum;
  logic       in_valid, in_ready, c_out, out_valid, out_ready;
  logic       a1, b1, iv1, ir1, s1, c1, ov1;
`ifdef HALF_ADDER_STATS_EN
  logic [15:0] carry_cnt, carry_cnt1;
  int          model_cnt;
`endif

  int         errors = 0;
  int         checks = 0;
  logic [8:0] exp_q[$];
  logic [8:0] prev_val;
  logic       prev_in_xfer;
  logic       prev_hold;
  logic       prev_ok;

  half_adder #(.WIDTH(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .in_valid(in_valid), .in_ready(in_ready),
    .sum(sum), .c_out(c_out), .out_valid(out_valid), .out_ready(out_ready)
`ifdef HALF_ADDER_STATS_EN
    , .carry_cnt(carry_cnt)
`endif
  );

  half_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .in_valid(iv1), .in_ready(ir1),
    .sum(s1), .c_out(c1), .out_valid(ov1), .out_ready(1'b1)
`ifdef HALF_ADDER_STATS_EN
    , .carry_cnt(carry_cnt1)
`endif
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // scoreboard monitor: reference result is the plain integer sum of the accepted pair
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      prev_ok = 1'b0;
`ifdef HALF_ADDER_STATS_EN
      model_cnt = 0;
`endif
    end else begin
      if (prev_ok && !prev_in_xfer) check("stable_data", {c_out, sum}, prev_val);
      if (prev_ok && prev_hold) check("hold_valid", out_valid, 1);
      check("in_ready_rule", in_ready, !out_valid || out_ready);
      check("valid_vs_queue", out_valid, exp_q.size() != 0);
`ifdef HALF_ADDER_STATS_EN
      check("carry_cnt", carry_cnt, model_cnt);
`endif
      if (out_valid && out_ready && exp_q.size() != 0)
        check("result", {c_out, sum}, exp_q.pop_front());
      if (in_valid && in_ready) begin
        exp_q.push_back(9'(int'(a) + int'(b)));
`ifdef HALF_ADDER_STATS_EN
        if (int'(a) + int'(b) > 255 && model_cnt < 65535) model_cnt++;
`endif
      end
      prev_in_xfer = in_valid && in_ready;
      prev_hold    = out_valid && !out_ready;
      prev_val     = {c_out, sum};
      prev_ok      = 1'b1;
    end
  end

  // driver tasks (all called and returning at posedge+1)
  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic send(input logic [7:0] x, input logic [7:0] y);
    bit ok = 0;
    a = x; b = y; in_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send_timeout: pair %0h+%0h not accepted within 50 cycles", x, y);
    end
  endtask

  task automatic drain();
    bit ok = 0;
    out_ready = 1'b1; in_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d results still pending", exp_q.size());
    end
  endtask

  initial begin
    rst_n = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; a = 8'd3; b = 8'd4;
    iv1 = 1'b1; a1 = 1'b1; b1 = 1'b1;
    prev_ok = 1'b0; prev_in_xfer = 1'b0; prev_hold = 1'b0; prev_val = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1; in_valid = 1'b0; iv1 = 1'b0;

    // reset state; inputs offered during reset must not have been taken
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_c_out", c_out, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_w1_valid", ov1, 0);

    // 1-bit truth table, back to back
    @(posedge clk); #1;
    iv1 = 1'b1; {a1, b1} = 2'b00;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (i < 3) {a1, b1} = 2'(i + 1);
      else iv1 = 1'b0;
      @(negedge clk);
      check("w1_result", {c1, s1}, ((i >> 1) & 1) + (i & 1));
      check("w1_valid", ov1, 1);
    end
    @(posedge clk); #1;

    // 8-bit boundaries
    send(8'hFF, 8'h01);
    @(negedge clk);
    check("ff_plus_1_sum", sum, 8'h00);
    check("ff_plus_1_cout", c_out, 1);
    @(posedge clk); #1;
    send(8'h7F, 8'h01);
    @(negedge clk);
    check("7f_plus_1_sum", sum, 8'h80);
    check("7f_plus_1_cout", c_out, 0);
    @(posedge clk); #1;
    drain();

    // backpressure: 3+4 held while a second pair waits
    out_ready = 1'b0;
    send(8'd3, 8'd4);
    a = 8'd5; b = 8'd6; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_sum", sum, 7);
      check("bp_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    check("bp_second_sum", sum, 11);
    @(posedge clk); #1;
    drain();

    // reset while a result is pending
    out_ready = 1'b0;
    send(8'd9, 8'd9);
    do_reset(1);
    @(negedge clk);
    check("midrst_valid", out_valid, 0);
    check("midrst_sum", sum, 0);
    check("midrst_c_out", c_out, 0);
    check("midrst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // random traffic with random backpressure; pairs are held until accepted
    begin
      bit acc;
      for (int i = 0; i < 400; i++) begin
        @(negedge clk);
        acc = in_valid && in_ready;
        @(posedge clk); #1;
        out_ready = ($urandom_range(0, 3) != 0);
        if (!in_valid || acc) begin
          in_valid = ($urandom_range(0, 3) != 0);
          a = 8'($urandom_range(0, 255));
          b = 8'($urandom_range(0, 255));
        end
      end
    end
    drain();

`ifdef HALF_ADDER_STATS_EN
    do_reset(2);
    for (int i = 0; i < 5; i++) send(8'd200, 8'($urandom_range(100, 255)));
    for (int i = 0; i < 3; i++) send(8'($urandom_range(0, 100)), 8'd2);
    @(negedge clk);
    check("cnt_five", carry_cnt, 5);
    @(posedge clk); #1;
    a = 8'hFF; b = 8'hFF; in_valid = 1'b1;
    repeat (70000) @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("cnt_saturated", carry_cnt, 16'hFFFF);
    @(posedge clk); #1;
    drain();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
